// File: rtl/sva_pkg.sv
// Shared types for the SVA result collector: event kinds, verdict states,
// the default event record and the result-priority helper.
package sva_pkg;

  localparam int SVA_STAMP_W = 16;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_SUCC = 2'd1,
    EVT_FAIL = 2'd2,
    EVT_LAZY = 2'd3
  } evt_kind_t;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_RUN  = 2'd1,
    V_FAIL = 2'd2
  } verdict_t;

  typedef struct packed {
    evt_kind_t              kind;
    logic [SVA_STAMP_W-1:0] stamp;
  } sva_evt_t;

  // One event per result cycle; a failure outranks a success, which outranks a lazy success.
  function automatic evt_kind_t sel_kind(input logic f, input logic s, input logic l);
    evt_kind_t k;
    if (f) begin
      k = EVT_FAIL;
    end else if (s) begin
      k = EVT_SUCC;
    end else if (l) begin
      k = EVT_LAZY;
    end else begin
      k = EVT_NONE;
    end
    return k;
  endfunction

endpackage

// File: rtl/sva_evt_fifo.sv
// First-word-fall-through event FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sva_evt_fifo
  import sva_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = sva_evt_t
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_pop;
  logic        w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers; clear empties the FIFO and overrides any push/pop.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents need no reset because the output is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/sva_result_collector.sv
// Collects SVA evaluator results: saturating succ/fail/lazy counters, gclk
// round index, sticky verdict FSM and a stamped event stream via sva_evt_fifo.
// Optional feature macro: SVA_COLLECT_LAZY_EN (lazy_succ counted and logged).
module sva_result_collector
  import sva_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int STAMP_WIDTH = 16,
  parameter int EVT_DEPTH   = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   clr,
  input  logic                   gclk_posedge_flag,
  input  logic                   res_valid,
  input  logic                   succ,
  input  logic                   fail,
  input  logic                   lazy_succ,
  output logic [CNT_WIDTH-1:0]   succ_cnt,
  output logic [CNT_WIDTH-1:0]   fail_cnt,
  output logic [CNT_WIDTH-1:0]   lazy_cnt,
  output logic [STAMP_WIDTH-1:0] round_idx,
  output logic [1:0]             verdict,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [1:0]             evt_kind,
  output logic [STAMP_WIDTH-1:0] evt_stamp,
  output logic                   evt_ovf
);

`ifdef SVA_COLLECT_LAZY_EN
  localparam logic LAZY_EN = 1'b1;
`else
  localparam logic LAZY_EN = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]           ST_IDLE = V_IDLE;
  localparam logic [1:0]           ST_RUN  = V_RUN;
  localparam logic [1:0]           ST_FAIL = V_FAIL;

  typedef struct packed {
    evt_kind_t              kind;
    logic [STAMP_WIDTH-1:0] stamp;
  } evt_t;

  logic                   w_clr;
  logic                   w_succ;
  logic                   w_fail;
  logic                   w_lazy;
  logic                   w_push;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;
  evt_t                   w_push_evt;
  evt_t                   w_head;
  logic [CNT_WIDTH-1:0]   r_succ_cnt;
  logic [CNT_WIDTH-1:0]   r_fail_cnt;
  logic [CNT_WIDTH-1:0]   r_lazy_cnt;
  logic [STAMP_WIDTH-1:0] r_round;
  logic [1:0]             r_verdict;
  logic                   r_ovf;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    logic [CNT_WIDTH-1:0] n;
    if (en && (v != CNT_MAX)) begin
      n = v + CNT_ONE;
    end else begin
      n = v;
    end
    return n;
  endfunction

  assign w_clr  = sys_rst | clr;
  assign w_succ = res_valid & succ;
  assign w_fail = res_valid & fail;
  assign w_lazy = res_valid & lazy_succ & LAZY_EN;
  assign w_push = w_succ | w_fail | w_lazy;
  // Full implies non-empty, so evt_ready alone decides whether a slot frees up.
  assign w_drop = w_push & w_full & ~evt_ready;

  assign w_push_evt.kind  = sel_kind(w_fail, w_succ, w_lazy);
  assign w_push_evt.stamp = r_round;

  sva_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_clear (clr),
    .i_push  (w_push),
    .i_data  (w_push_evt),
    .i_pop   (evt_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt_valid = ~w_empty;
  assign evt_kind  = w_empty ? 2'b00 : w_head.kind;
  assign evt_stamp = w_empty ? {STAMP_WIDTH{1'b0}} : w_head.stamp;
  assign succ_cnt  = r_succ_cnt;
  assign fail_cnt  = r_fail_cnt;
  assign lazy_cnt  = r_lazy_cnt;
  assign round_idx = r_round;
  assign verdict   = r_verdict;
  assign evt_ovf   = r_ovf;

  // Saturating result counters, round index and sticky overflow flag.
  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_succ_cnt <= {CNT_WIDTH{1'b0}};
      r_fail_cnt <= {CNT_WIDTH{1'b0}};
      r_lazy_cnt <= {CNT_WIDTH{1'b0}};
      r_round    <= {STAMP_WIDTH{1'b0}};
      r_ovf      <= 1'b0;
    end else begin
      r_succ_cnt <= sat_inc(r_succ_cnt, w_succ);
      r_fail_cnt <= sat_inc(r_fail_cnt, w_fail);
      r_lazy_cnt <= sat_inc(r_lazy_cnt, w_lazy);
      if (gclk_posedge_flag) begin
        r_round <= r_round + {{(STAMP_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Verdict FSM: idle until the first result, any failure is sticky, code 3 recovers to idle.
  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_verdict <= ST_IDLE;
    end else begin
      case (r_verdict)
        ST_IDLE: begin
          if (w_fail) begin
            r_verdict <= ST_FAIL;
          end else if (w_succ || w_lazy) begin
            r_verdict <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_fail) begin
            r_verdict <= ST_FAIL;
          end
        end
        ST_FAIL: r_verdict <= ST_FAIL;
        default: r_verdict <= ST_IDLE;
      endcase
    end
  end

endmodule
